// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder feeding a first-word-fall-through FIFO of decoded entries.
// Define DECODE_RV32M_EN to also decode RV32M (funct7=0000001) as legal mul/div ops.
module decode_stage #(
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr_in,
   input  logic [PC_WIDTH-1:0]   pc_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_WIDTH-1:0]   out_pc,
   output logic [3:0]            out_alu_op,
   output logic [1:0]            out_alu_src,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic [1:0]            out_mem_to_reg,
   output logic                  out_branch,
   output logic                  out_jump,
   output logic [2:0]            out_funct3,
   output logic [4:0]            out_rd,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [31:0]           out_imm,
   output logic                  out_illegal,
   output logic                  out_muldiv,
   output logic [2:0]            out_muldiv_op,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                          OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_LUI = 7'b0110111,
                          OPC_AUI = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [3:0]          alu_op;
      logic [1:0]          alu_src;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic [1:0]          mem_to_reg;
      logic                branch;
      logic                jump;
      logic [2:0]          funct3;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [31:0]         imm;
      logic                illegal;
      logic                muldiv;
      logic [2:0]          muldiv_op;
   } entry_t;
   entry_t        r_mem [DEPTH];
   entry_t        w_dec;
   entry_t        w_head;
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic [6:0]    w_opc;
   logic [6:0]    w_f7;
   logic [2:0]    w_f3;
   logic [3:0]    w_alu;
   logic          w_ill;
   logic          w_m;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_imm_i;
   logic [31:0]   w_imm_s;
   logic [31:0]   w_imm_b;
   logic [31:0]   w_imm_u;
   logic [31:0]   w_imm_j;
   assign w_opc   = instr_in[6:0];
   assign w_f3    = instr_in[14:12];
   assign w_f7    = instr_in[31:25];
   assign w_imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
   assign w_imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
   assign w_imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
   assign w_imm_u = {instr_in[31:12], 12'b0};
   assign w_imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
`ifdef DECODE_RV32M_EN
   assign w_m = (w_opc == OPC_R) && (w_f7 == 7'b0000001);
`else
   assign w_m = 1'b0;
`endif
   // funct3 to ALU op; funct7[5] picks SRA over SRL (SUB is handled for R-type only)
   always_comb begin
      w_alu = 4'b0000;
      case (w_f3)
         3'b001: w_alu = 4'b0101;
         3'b010: w_alu = 4'b1000;
         3'b011: w_alu = 4'b1001;
         3'b100: w_alu = 4'b0100;
         3'b101: w_alu = w_f7[5] ? 4'b0111 : 4'b0110;
         3'b110: w_alu = 4'b0011;
         3'b111: w_alu = 4'b0010;
         default: w_alu = 4'b0000;
      endcase
   end
   // register indices are the raw instruction fields regardless of format
   always_comb begin
      w_dec        = '0;
      w_ill        = 1'b0;
      w_dec.pc     = pc_in;
      w_dec.funct3 = w_f3;
      w_dec.rd     = instr_in[11:7];
      w_dec.rs1    = instr_in[19:15];
      w_dec.rs2    = instr_in[24:20];
      case (w_opc)
         OPC_R: begin
            w_dec.alu_op    = w_m ? 4'b0000 : (w_f3 == 3'b000 && w_f7[5]) ? 4'b0001 : w_alu;
            w_dec.reg_write = 1'b1;
            w_dec.muldiv    = w_m;
            w_dec.muldiv_op = w_m ? w_f3 : 3'b000;
            w_ill = !((w_f7 == 7'b0) || w_m ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         OPC_I: begin
            w_dec.alu_op    = w_alu;
            w_dec.alu_src   = 2'b01;
            w_dec.reg_write = 1'b1;
            w_dec.imm       = w_imm_i;
            w_ill = (w_f3 == 3'b001 && w_f7 != 7'b0) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != 7'b0100000);
         end
         OPC_LD: begin
            w_dec.alu_src    = 2'b01;
            w_dec.reg_write  = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 2'b11;
            w_dec.imm        = w_imm_i;
            w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         OPC_ST: begin
            w_dec.alu_src   = 2'b01;
            w_dec.mem_write = 1'b1;
            w_dec.imm       = w_imm_s;
            w_ill = (w_f3 > 3'b010);
         end
         OPC_BR: begin
            w_dec.alu_op = 4'b0001;
            w_dec.branch = 1'b1;
            w_dec.imm    = w_imm_b;
            w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         OPC_LUI: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 2'b01;
            w_dec.imm        = w_imm_u;
         end
         OPC_AUI: begin
            w_dec.alu_src   = 2'b11;
            w_dec.reg_write = 1'b1;
            w_dec.imm       = w_imm_u;
         end
         OPC_JAL: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 2'b10;
            w_dec.jump       = 1'b1;
            w_dec.imm        = w_imm_j;
         end
         OPC_JALR: begin
            w_dec.alu_src    = 2'b01;
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 2'b10;
            w_dec.jump       = 1'b1;
            w_dec.imm        = w_imm_i;
            w_ill = (w_f3 != 3'b000);
         end
         default: w_ill = 1'b1;
      endcase
      w_dec.illegal = w_ill;
      if (w_ill) begin
         w_dec.reg_write = 1'b0;
         w_dec.mem_read  = 1'b0;
         w_dec.mem_write = 1'b0;
         w_dec.branch    = 1'b0;
         w_dec.jump      = 1'b0;
         w_dec.muldiv    = 1'b0;
      end
   end
   assign in_ready  = (r_count < FULL) & ~flush & ~rst;
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready & ~flush;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_dec;
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_count <= (w_push & ~w_pop) ? r_count + 1'b1 :
                    (w_pop & ~w_push) ? r_count - 1'b1 : r_count;
      end
   end
   assign w_head         = out_valid ? r_mem[r_rp] : '0;
   assign out_pc         = w_head.pc;
   assign out_alu_op     = w_head.alu_op;
   assign out_alu_src    = w_head.alu_src;
   assign out_reg_write  = w_head.reg_write;
   assign out_mem_read   = w_head.mem_read;
   assign out_mem_write  = w_head.mem_write;
   assign out_mem_to_reg = w_head.mem_to_reg;
   assign out_branch     = w_head.branch;
   assign out_jump       = w_head.jump;
   assign out_funct3     = w_head.funct3;
   assign out_rd         = w_head.rd;
   assign out_rs1        = w_head.rs1;
   assign out_rs2        = w_head.rs2;
   assign out_imm        = w_head.imm;
   assign out_illegal    = w_head.illegal;
   assign out_muldiv     = w_head.muldiv;
   assign out_muldiv_op  = w_head.muldiv_op;
   assign count          = r_count;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with hand-decoded directed vectors.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr_in, pc_in, out_pc, out_imm;
   logic [3:0]  out_alu_op;
   logic [1:0]  out_alu_src, out_mem_to_reg, count;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal, out_muldiv;
   logic [2:0]  out_funct3, out_muldiv_op;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   int          checks = 0;
   int          errors = 0;
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [1:0]  alu_src;
      logic        rw, mr, mw;
      logic [1:0]  m2r;
      logic        br, jp;
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        ill, md;
      logic [2:0]  mdop;
   } exp_t;
   exp_t act;
   exp_t sb[$];
   always #5 clk = ~clk;
   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_jump(out_jump),
      .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_illegal(out_illegal), .out_muldiv(out_muldiv),
      .out_muldiv_op(out_muldiv_op), .count(count)
   );
   assign act = {out_pc, out_alu_op, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                 out_mem_to_reg, out_branch, out_jump, out_funct3, out_rd, out_rs1, out_rs2,
                 out_imm, out_illegal, out_muldiv, out_muldiv_op};
   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic [3:0] alu,
                               input logic [1:0] src, input logic rw, input logic mr, input logic mw,
                               input logic [1:0] m2r, input logic br, input logic jp,
                               input logic [31:0] imm, input logic ill, input logic md);
      exp_t e;
      e = {pc, alu, src, rw, mr, mw, m2r, br, jp, ins[14:12], ins[11:7], ins[19:15], ins[24:20],
           imm, ill, md, (md ? ins[14:12] : 3'b000)};
      return e;
   endfunction
   task automatic chk(input string nm, input logic [35:0] a, input logic [35:0] r);
      checks++;
      if (a !== r) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, a, r);
      end
   endtask
   task automatic send(input logic [31:0] ins, input exp_t e);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; instr_in = ins; pc_in = e.pc;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end else sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_entry pc=%h", out_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL entry pc=%h actual=%h required=%h", e.pc, act, e);
            end
         end
      end
   end
   initial begin
      int n;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr_in = '0; pc_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_pc", out_pc, 0);
      // first accept: visible one edge later
      send(32'h00500093, mk(32'h100, 32'h00500093, 4'b0000, 2'b01, 1, 0, 0, 2'b00, 0, 0, 32'h5, 0, 0));
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_count", count, 1);
      chk("lat_imm", out_imm, 32'h5);
      chk("lat_rd", out_rd, 1);
      @(posedge clk); #1 out_ready = 1'b1;
      send(32'h00309113, mk(32'h104, 32'h00309113, 4'b0101, 2'b01, 1, 0, 0, 2'b00, 0, 0, 32'h3, 0, 0));
      send(32'h4030D113, mk(32'h108, 32'h4030D113, 4'b0111, 2'b01, 1, 0, 0, 2'b00, 0, 0, 32'h403, 0, 0));
      send(32'hFE000EE3, mk(32'h10C, 32'hFE000EE3, 4'b0001, 2'b00, 0, 0, 0, 2'b00, 1, 0, 32'hFFFFFFFC, 0, 0));
      // fill to full, then drain while pushing
      @(posedge clk); #1 out_ready = 1'b0;
      send(32'h00812283, mk(32'h110, 32'h00812283, 4'b0000, 2'b01, 1, 1, 0, 2'b11, 0, 0, 32'h8, 0, 0));
      send(32'hFE512E23, mk(32'h114, 32'hFE512E23, 4'b0000, 2'b01, 0, 0, 1, 2'b00, 0, 0, 32'hFFFFFFFC, 0, 0));
      @(negedge clk);
      chk("full_count", count, 2);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      send(32'h123451B7, mk(32'h118, 32'h123451B7, 4'b0000, 2'b00, 1, 0, 0, 2'b01, 0, 0, 32'h12345000, 0, 0));
      @(negedge clk);
      chk("push_pop_count", count, 1);
      chk("push_pop_head_pc", out_pc, 32'h118);
      // flush with two queued entries and a concurrent offer
      @(posedge clk); #1 out_ready = 1'b0;
      send(32'h008000EF, mk(32'h11C, 32'h008000EF, 4'b0000, 2'b00, 1, 0, 0, 2'b10, 0, 1, 32'h8, 0, 0));
      send(32'h00008067, mk(32'h120, 32'h00008067, 4'b0000, 2'b01, 1, 0, 0, 2'b10, 0, 1, 32'h0, 0, 0));
      @(negedge clk);
      chk("pre_flush_count", count, 2);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; instr_in = 32'h00100093; pc_in = 32'h999;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("flush_count", count, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready_after", in_ready, 1);
      @(posedge clk); #1 out_ready = 1'b1;
      send(32'h00001217, mk(32'h124, 32'h00001217, 4'b0000, 2'b11, 1, 0, 0, 2'b00, 0, 0, 32'h1000, 0, 0));
      send(32'h402081B3, mk(32'h128, 32'h402081B3, 4'b0001, 2'b00, 1, 0, 0, 2'b00, 0, 0, 32'h0, 0, 0));
      send(32'h0000007F, mk(32'h12C, 32'h0000007F, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 0));
`ifdef DECODE_RV32M_EN
      send(32'h02208033, mk(32'h130, 32'h02208033, 4'b0000, 2'b00, 1, 0, 0, 2'b00, 0, 0, 32'h0, 0, 1));
`else
      send(32'h02208033, mk(32'h130, 32'h02208033, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 0));
`endif
      send(32'h00009067, mk(32'h134, 32'h00009067, 4'b0000, 2'b01, 0, 0, 0, 2'b10, 0, 0, 32'h0, 1, 0));
      send(32'h00002063, mk(32'h138, 32'h00002063, 4'b0001, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 0));
      send(32'h40209033, mk(32'h13C, 32'h40209033, 4'b0101, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 0));
      send(32'h00000010, mk(32'h140, 32'h00000010, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1, 0));
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         n++;
         @(posedge clk);
      end
      chk("drain_left", sb.size(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("empty_count", count, 0);
      chk("empty_out_valid", out_valid, 0);
      chk("empty_imm", out_imm, 0);
      chk("empty_pc", out_pc, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
